// File: rtl/hi_fanin_collect.sv
// Wide fan-in collector: samples NUM_SRC bits, then reduces them through a
// registered RADIX-ary OR/AND/XOR/XNOR tree to one output flop with a hit counter.
module hi_fanin_collect #(
  parameter int unsigned NUM_SRC = 68,
  parameter int unsigned RADIX   = 4,
  parameter int unsigned CNT_W   = 8
) (
  input  logic               clk1,
  input  logic               rst_n,
  input  logic               en,
  input  logic [NUM_SRC-1:0] src,
  input  logic [1:0]         mode,
  input  logic               cnt_clr,
  output logic               out_q,
  output logic               out_vld,
  output logic [CNT_W-1:0]   hit_cnt
);

  function automatic int unsigned lvl_width(input int unsigned lvl);
    int unsigned w;
    w = NUM_SRC;
    for (int unsigned i = 0; i < lvl; i++) w = (w + RADIX - 1) / RADIX;
    return w;
  endfunction

  function automatic int unsigned tree_depth();
    int unsigned w;
    int unsigned d;
    w = NUM_SRC;
    d = 0;
    while (w > 1) begin
      w = (w + RADIX - 1) / RADIX;
      d++;
    end
    return d;
  endfunction

  localparam int unsigned D = tree_depth();

  typedef enum logic [1:0] {
    M_OR   = 2'b00,
    M_AND  = 2'b01,
    M_XOR  = 2'b10,
    M_XNOR = 2'b11
  } mode_e;

  logic [NUM_SRC-1:0] cap_q;
  mode_e              mode_q [0:D-1];
  logic [D:0]         vld_q;
  logic [CNT_W-1:0]   hit_q;
  logic [CNT_W-1:0]   hit_d;

  // Valid and mode advance every cycle so each sample carries its own mode.
  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) begin
      cap_q <= '0;
      vld_q <= '0;
      for (int unsigned i = 0; i < D; i++) mode_q[i] <= M_OR;
    end else begin
      vld_q[0] <= en;
      if (en) begin
        cap_q     <= src;
        mode_q[0] <= mode_e'(mode);
      end
      for (int unsigned i = 1; i <= D; i++) vld_q[i] <= vld_q[i-1];
      for (int unsigned i = 1; i < D; i++) mode_q[i] <= mode_q[i-1];
    end
  end

  for (genvar l = 1; l <= D; l++) begin : g_lvl
    localparam int unsigned WI = lvl_width(l - 1);
    localparam int unsigned WO = lvl_width(l);

    mode_e                 m_w;
    logic [WI-1:0]         in_w;
    logic [WO*RADIX-1:0]   pad_w;
    logic [WO-1:0]         d_d;
    logic [WO-1:0]         d_q;

    assign m_w = mode_q[l-1];

    if (l == 1) begin : g_in
      assign in_w = cap_q;
    end else begin : g_in
      assign in_w = g_lvl[l-1].d_q;
    end

    // Short last group is filled with the mode's identity; XNOR runs as XOR
    // through the tree and is inverted only at the final level.
    always_comb begin
      pad_w          = (m_w == M_AND) ? '1 : '0;
      pad_w[WI-1:0]  = in_w;
      d_d            = '0;
      for (int unsigned n = 0; n < WO; n++) begin
        unique case (m_w)
          M_OR:          d_d[n] = |pad_w[n*RADIX +: RADIX];
          M_AND:         d_d[n] = &pad_w[n*RADIX +: RADIX];
          M_XOR, M_XNOR: d_d[n] = ^pad_w[n*RADIX +: RADIX];
        endcase
      end
      if (l == D && m_w == M_XNOR) d_d = ~d_d;
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n)           d_q <= '0;
      else if (vld_q[l-1])  d_q <= d_d;
    end
  end

  always_comb begin
    hit_d = hit_q;
    if (cnt_clr)                                hit_d = '0;
    else if (out_vld && out_q && hit_q != '1)   hit_d = hit_q + 1'b1;
  end

  always_ff @(posedge clk1 or negedge rst_n) begin
    if (!rst_n) hit_q <= '0;
    else        hit_q <= hit_d;
  end

  assign out_q   = g_lvl[D].d_q[0];
  assign out_vld = vld_q[D];
  assign hit_cnt = hit_q;

endmodule

// File: tb/tb_hi_fanin_collect.sv
// Directed bench for hi_fanin_collect: vector table plus hand sequences for
// reset, pipelining, counter saturation/clear, D=1 padding and mid-flight reset.
module tb_hi_fanin_collect;

  logic        clk1 = 1'b0;
  logic        rst_n;
  logic        en;
  logic [67:0] src;
  logic [1:0]  mode;
  logic        cnt_clr;

  logic        q8, v8, q4, v4, qs, vs;
  logic [7:0]  h8;
  logic [3:0]  h4;
  logic [7:0]  hs;

  int n_cmp = 0;
  int n_err = 0;
  int exp8  = 0;
  int exp4  = 0;

  always #5 clk1 = ~clk1;

  hi_fanin_collect #(.NUM_SRC(68), .RADIX(4), .CNT_W(8)) dut8 (
    .clk1(clk1), .rst_n(rst_n), .en(en), .src(src), .mode(mode),
    .cnt_clr(cnt_clr), .out_q(q8), .out_vld(v8), .hit_cnt(h8));

  hi_fanin_collect #(.NUM_SRC(68), .RADIX(4), .CNT_W(4)) dut4 (
    .clk1(clk1), .rst_n(rst_n), .en(en), .src(src), .mode(mode),
    .cnt_clr(cnt_clr), .out_q(q4), .out_vld(v4), .hit_cnt(h4));

  hi_fanin_collect #(.NUM_SRC(3), .RADIX(4), .CNT_W(8)) duts (
    .clk1(clk1), .rst_n(rst_n), .en(en), .src(src[2:0]), .mode(mode),
    .cnt_clr(cnt_clr), .out_q(qs), .out_vld(vs), .hit_cnt(hs));

  typedef struct {
    logic [67:0] src;
    logic [1:0]  mode;
    logic        exp_q;
  } vec_t;

  vec_t vecs [13];
  vec_t svec [3];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk1);
    #1;
  endtask

  task automatic bump();
    exp8 = (exp8 < 255) ? exp8 + 1 : 255;
    exp4 = (exp4 < 15)  ? exp4 + 1 : 15;
  endtask

  initial begin
    logic [67:0] all1;
    logic [67:0] one67;
    logic        pq [4];
    all1  = '1;
    one67 = '0;
    one67[67] = 1'b1;

    vecs[0]  = '{one67,             2'b00, 1'b1};
    vecs[1]  = '{68'h0,             2'b00, 1'b0};
    vecs[2]  = '{all1,              2'b01, 1'b1};
    vecs[3]  = '{all1 ^ 68'h1,      2'b01, 1'b0};
    vecs[4]  = '{68'h3,             2'b10, 1'b0};
    vecs[5]  = '{68'h3,             2'b11, 1'b1};
    vecs[6]  = '{68'h1,             2'b10, 1'b1};
    vecs[7]  = '{68'h0,             2'b11, 1'b1};
    vecs[8]  = '{all1,              2'b10, 1'b0};
    vecs[9]  = '{all1,              2'b11, 1'b1};
    vecs[10] = '{68'h0,             2'b01, 1'b0};
    vecs[11] = '{all1,              2'b00, 1'b1};
    vecs[12] = '{one67,             2'b10, 1'b1};

    svec[0]  = '{all1,              2'b01, 1'b1};
    svec[1]  = '{68'h3,             2'b01, 1'b0};
    svec[2]  = '{68'h3,             2'b11, 1'b1};

    pq[0] = 1'b1; pq[1] = 1'b0; pq[2] = 1'b0; pq[3] = 1'b1;

    // Reset held with active inputs
    rst_n = 1'b0; en = 1'b1; src = all1; mode = 2'b00; cnt_clr = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("rst_out_q", {31'd0, q8}, 32'd0);
      chk("rst_out_vld", {31'd0, v8}, 32'd0);
      chk("rst_hit_cnt", {24'd0, h8}, 32'd0);
      step();
    end
    rst_n = 1'b1;
    step();
    en = 1'b0;
    step(); step(); step();
    chk("rst_first_vld_early", {31'd0, v8}, 32'd0);
    step();
    chk("rst_first_vld", {31'd0, v8}, 32'd1);
    chk("rst_first_q", {31'd0, q8}, 32'd1);
    bump();
    step();
    chk("rst_first_hit", {24'd0, h8}, exp8);

    // Single-pulse vector table
    for (int i = 0; i < 13; i++) begin
      src = vecs[i].src; mode = vecs[i].mode; en = 1'b1;
      step();
      en = 1'b0;
      step(); step(); step();
      chk("vec_vld_early", {31'd0, v8}, 32'd0);
      step();
      chk("vec_vld", {31'd0, v8}, 32'd1);
      chk("vec_q", {31'd0, q8}, {31'd0, vecs[i].exp_q});
      chk("vec_q_cnt4", {31'd0, q4}, {31'd0, vecs[i].exp_q});
      chk("vec_vld_cnt4", {31'd0, v4}, 32'd1);
      if (vecs[i].exp_q) bump();
      step();
      chk("vec_vld_pulse", {31'd0, v8}, 32'd0);
      chk("vec_q_hold", {31'd0, q8}, {31'd0, vecs[i].exp_q});
      chk("vec_hit", {24'd0, h8}, exp8);
    end

    // NUM_SRC <= RADIX instance: one level, pad still applies
    for (int i = 0; i < 3; i++) begin
      src = svec[i].src; mode = svec[i].mode; en = 1'b1;
      step();
      en = 1'b0;
      step();
      chk("d1_vld", {31'd0, vs}, 32'd1);
      chk("d1_q", {31'd0, qs}, {31'd0, svec[i].exp_q});
      step(); step(); step();
      chk("d1_main_q", {31'd0, q8}, {31'd0, svec[i].exp_q});
      if (svec[i].exp_q) bump();
      step();
      chk("d1_main_hit", {24'd0, h8}, exp8);
    end

    // Back-to-back samples with a different mode each cycle
    src = 68'h3;
    for (int i = 0; i < 4; i++) begin
      mode = i[1:0]; en = 1'b1;
      step();
    end
    en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("pipe_vld", {31'd0, v8}, 32'd1);
      chk("pipe_q", {31'd0, q8}, {31'd0, pq[i]});
      if (pq[i]) bump();
    end
    step();
    chk("pipe_vld_end", {31'd0, v8}, 32'd0);
    chk("pipe_hit", {24'd0, h8}, exp8);

    // Saturation: 20 consecutive OR hits
    src = all1; mode = 2'b00; en = 1'b1;
    for (int i = 0; i < 20; i++) step();
    en = 1'b0;
    for (int i = 0; i < 6; i++) step();
    for (int i = 0; i < 20; i++) bump();
    chk("sat_hit4", {28'd0, h4}, 32'd15);
    chk("sat_hit8", {24'd0, h8}, exp8);

    // Clear on the same cycle as a hit wins
    en = 1'b1;
    step();
    en = 1'b0;
    step(); step(); step(); step();
    chk("clr_hit_vld", {31'd0, v8}, 32'd1);
    cnt_clr = 1'b1;
    step();
    cnt_clr = 1'b0;
    exp8 = 0; exp4 = 0;
    chk("clr_hit4", {28'd0, h4}, 32'd0);
    chk("clr_hit8", {24'd0, h8}, 32'd0);
    step();
    chk("clr_hit8_stay", {24'd0, h8}, 32'd0);

    // Make out_q and hit_cnt nonzero, then reset mid-flight
    en = 1'b1;
    step();
    en = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("pre_mid_q", {31'd0, q8}, 32'd1);
    chk("pre_mid_hit", {24'd0, h8}, 32'd1);
    en = 1'b1;
    step();
    en = 1'b0;
    step(); step();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_q", {31'd0, q8}, 32'd0);
    chk("mid_rst_vld", {31'd0, v8}, 32'd0);
    chk("mid_rst_hit", {24'd0, h8}, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      step();
      chk("mid_no_vld", {31'd0, v8}, 32'd0);
    end
    en = 1'b1;
    step();
    en = 1'b0;
    step(); step(); step(); step();
    chk("mid_new_vld", {31'd0, v8}, 32'd1);
    chk("mid_new_q", {31'd0, q8}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
